// File: rtl/viu_tag_insert_param.sv
// 802.1Q tag inserter for the VIU TX path: bypass, insert or replace-if-tagged per packet.
// Optional per-packet statistics counters are enabled with `define VIU_TAG_STATS_EN.
module viu_tag_insert_param #(
    parameter int          DATA_WIDTH  = 512,
    parameter int          TAG_OFFSET  = 12,
    parameter logic [15:0] VLAN_TPID   = 16'h8100,
    parameter int          ROUTE_WIDTH = 14
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ROUTE_WIDTH-1:0]    route_in,
    input  logic [2:0]                pcp_in,
    input  logic [1:0]                mode_in,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
`ifdef VIU_TAG_STATS_EN
    ,
    output logic [31:0]               stat_inserted,
    output logic [31:0]               stat_replaced,
    output logic [31:0]               stat_bypassed
`endif
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int O     = TAG_OFFSET;

    // Both AXIS ports use the same handshake: a beat moves on a rising aclk
    // where valid and ready are both high; valid never waits on ready, and
    // data/keep/last stay stable while valid is high and ready is low.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]           carry_data, carry_data_nxt;
    logic [3:0]            carry_keep, carry_keep_nxt;

    logic                  out_load;
    logic                  in_hs;
    logic                  out_valid_nxt;
    logic [DATA_WIDTH-1:0] out_data_nxt;
    logic [BYTES-1:0]      out_keep_nxt;
    logic                  out_last_nxt;

    logic [15:0]           tci;
    logic [31:0]           tag_bytes;
    logic                  is_runt, is_bypass, is_tagged, top_empty;
    logic                  cnt_ins, cnt_rep, cnt_byp;

    logic [DATA_WIDTH-1:0] ins_data, rep_data, shift_data, drain_data;
    logic [BYTES-1:0]      ins_keep, shift_keep, drain_keep;

    logic                  unused_route;

    assign out_load      = ~m_axis_tvalid | m_axis_tready;
    assign s_axis_tready = aresetn & out_load & (state != ST_DRAIN);
    assign in_hs         = s_axis_tvalid & s_axis_tready;

    // Only a subset of the routing word contributes to the VID.
    assign tci          = {pcp_in, 1'b0, route_in[9:6], 6'b0, route_in[1:0]};
    assign unused_route = ^route_in;

    // Byte O is the lowest-addressed byte on the wire, so TPID high byte sits lowest.
    assign tag_bytes = {tci[7:0], tci[15:8], VLAN_TPID[7:0], VLAN_TPID[15:8]};

    assign is_runt   = ~s_axis_tkeep[O+1];
    assign is_bypass = (mode_in == 2'b00) || (mode_in == 2'b11);
    assign is_tagged = (mode_in == 2'b10) &&
                       (s_axis_tdata[8*O +: 16] == {VLAN_TPID[7:0], VLAN_TPID[15:8]});
    assign top_empty = (s_axis_tkeep[BYTES-1 -: 4] == 4'b0000);

    assign ins_data   = {s_axis_tdata[DATA_WIDTH-33:8*O], tag_bytes, s_axis_tdata[8*O-1:0]};
    assign ins_keep   = {s_axis_tkeep[BYTES-5:O], 4'hF, s_axis_tkeep[O-1:0]};
    assign shift_data = {s_axis_tdata[DATA_WIDTH-33:0], carry_data};
    assign shift_keep = {s_axis_tkeep[BYTES-5:0], carry_keep};
    assign drain_data = {{(DATA_WIDTH-32){1'b0}}, carry_data};
    assign drain_keep = {{(BYTES-4){1'b0}}, carry_keep};

    always_comb begin
        rep_data = s_axis_tdata;
        rep_data[8*O+16 +: 16] = {tci[7:0], tci[15:8]};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= ST_IDLE;
            carry_data <= '0;
            carry_keep <= '0;
        end else begin
            state      <= state_nxt;
            carry_data <= carry_data_nxt;
            carry_keep <= carry_keep_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        carry_data_nxt = carry_data;
        carry_keep_nxt = carry_keep;
        out_valid_nxt  = 1'b0;
        out_data_nxt   = s_axis_tdata;
        out_keep_nxt   = s_axis_tkeep;
        out_last_nxt   = s_axis_tlast;
        cnt_ins        = 1'b0;
        cnt_rep        = 1'b0;
        cnt_byp        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_hs) begin
                    out_valid_nxt = 1'b1;
                    if (is_runt || is_bypass) begin
                        cnt_byp   = 1'b1;
                        state_nxt = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end else if (is_tagged) begin
                        cnt_rep      = 1'b1;
                        out_data_nxt = rep_data;
                        state_nxt    = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end else begin
                        cnt_ins        = 1'b1;
                        out_data_nxt   = ins_data;
                        out_keep_nxt   = ins_keep;
                        carry_data_nxt = s_axis_tdata[DATA_WIDTH-1 -: 32];
                        carry_keep_nxt = s_axis_tkeep[BYTES-1 -: 4];
                        if (!s_axis_tlast) begin
                            out_last_nxt = 1'b0;
                            state_nxt    = ST_SHIFT;
                        end else if (top_empty) begin
                            out_last_nxt = 1'b1;
                            state_nxt    = ST_IDLE;
                        end else begin
                            out_last_nxt = 1'b0;
                            state_nxt    = ST_DRAIN;
                        end
                    end
                end
            end
            ST_PASS: begin
                if (in_hs) begin
                    out_valid_nxt = 1'b1;
                    if (s_axis_tlast) state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (in_hs) begin
                    out_valid_nxt  = 1'b1;
                    out_data_nxt   = shift_data;
                    out_keep_nxt   = shift_keep;
                    carry_data_nxt = s_axis_tdata[DATA_WIDTH-1 -: 32];
                    carry_keep_nxt = s_axis_tkeep[BYTES-1 -: 4];
                    if (!s_axis_tlast) begin
                        out_last_nxt = 1'b0;
                    end else if (top_empty) begin
                        out_last_nxt = 1'b1;
                        state_nxt    = ST_IDLE;
                    end else begin
                        out_last_nxt = 1'b0;
                        state_nxt    = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The four bytes pushed past the end of the last beat go out alone.
                if (out_load) begin
                    out_valid_nxt = 1'b1;
                    out_data_nxt  = drain_data;
                    out_keep_nxt  = drain_keep;
                    out_last_nxt  = 1'b1;
                    state_nxt     = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (out_load) begin
            m_axis_tvalid <= out_valid_nxt;
            m_axis_tdata  <= out_data_nxt;
            m_axis_tkeep  <= out_keep_nxt;
            m_axis_tlast  <= out_last_nxt;
        end
    end

`ifdef VIU_TAG_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stat_inserted <= '0;
            stat_replaced <= '0;
            stat_bypassed <= '0;
        end else begin
            if (cnt_ins && (stat_inserted != 32'hFFFF_FFFF)) stat_inserted <= stat_inserted + 32'd1;
            if (cnt_rep && (stat_replaced != 32'hFFFF_FFFF)) stat_replaced <= stat_replaced + 32'd1;
            if (cnt_byp && (stat_bypassed != 32'hFFFF_FFFF)) stat_bypassed <= stat_bypassed + 32'd1;
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = cnt_ins ^ cnt_rep ^ cnt_byp;
`endif

endmodule

// File: tb/tb_viu_tag_insert_param.sv
// Scoreboard bench for viu_tag_insert_param at its default 512-bit, offset-12 configuration.
// Define VIU_TAG_STATS_EN for both files to also check the statistics counters.
module tb_viu_tag_insert_param;

    localparam int DW = 512;
    localparam int NB = DW / 8;
    localparam int O  = 12;

    logic           aclk = 1'b0;
    logic           aresetn;
    logic [13:0]    route_in;
    logic [2:0]     pcp_in;
    logic [1:0]     mode_in;
    logic [DW-1:0]  s_axis_tdata;
    logic [NB-1:0]  s_axis_tkeep;
    logic           s_axis_tlast;
    logic           s_axis_tvalid;
    logic           s_axis_tready;
    logic [DW-1:0]  m_axis_tdata;
    logic [NB-1:0]  m_axis_tkeep;
    logic           m_axis_tlast;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
`ifdef VIU_TAG_STATS_EN
    logic [31:0]    stat_inserted, stat_replaced, stat_bypassed;
`endif

    viu_tag_insert_param dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .route_in      (route_in),
        .pcp_in        (pcp_in),
        .mode_in       (mode_in),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
`ifdef VIU_TAG_STATS_EN
        ,
        .stat_inserted (stat_inserted),
        .stat_replaced (stat_replaced),
        .stat_bypassed (stat_bypassed)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit mon_en   = 1'b0;
    bit rdy_mode = 1'b0;  // 0: ready held high, 1: ready toggles every cycle

    logic [DW-1:0] exp_data_q[$];
    logic [NB-1:0] exp_keep_q[$];
    logic          exp_last_q[$];
    int exp_ins = 0, exp_rep = 0, exp_byp = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            if (rdy_mode) m_axis_tready = ~m_axis_tready;
            else          m_axis_tready = 1'b1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [DW-1:0] hold_data;
    logic [NB-1:0] hold_keep;
    logic          hold_last;
    bit            hold_v = 1'b0;

    initial begin
        forever begin
            @(negedge aclk);
            if (!mon_en) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("stall_valid", DW'(m_axis_tvalid), DW'(1'b1));
                    chk("stall_data",  m_axis_tdata, hold_data);
                    chk("stall_keep",  DW'(m_axis_tkeep), DW'(hold_keep));
                    chk("stall_last",  DW'(m_axis_tlast), DW'(hold_last));
                end
                hold_v = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_data_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_beat: got keep %0h expected no beat", m_axis_tkeep);
                    end else begin
                        chk("out_data", m_axis_tdata, exp_data_q.pop_front());
                        chk("out_keep", DW'(m_axis_tkeep), DW'(exp_keep_q.pop_front()));
                        chk("out_last", DW'(m_axis_tlast), DW'(exp_last_q.pop_front()));
                    end
                end else if (m_axis_tvalid) begin
                    hold_v    = 1'b1;
                    hold_data = m_axis_tdata;
                    hold_keep = m_axis_tkeep;
                    hold_last = m_axis_tlast;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        bit hs;
        bit ok;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge aclk);
            hs = s_axis_tready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL drive_timeout: got tready low for 200 cycles expected acceptance");
        end
    endtask

    // exp_tci is the hand-computed TCI for the given route/pcp.
    task automatic send_pkt(input int len, input logic [1:0] mode, input logic [13:0] route,
                            input logic [2:0] pcp, input logic [15:0] exp_tci, input bit pre_tagged);
        logic [7:0]    pb[0:255];
        logic [7:0]    ob[0:259];
        int            olen;
        int            nbo;
        int            nbi;
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        for (int i = 0; i < 256; i++) pb[i] = 8'(i * 7 + len);
        if (pre_tagged) begin
            pb[12] = 8'h81; pb[13] = 8'h00; pb[14] = 8'hFF; pb[15] = 8'hFF;
        end
        if (len <= O + 1 || mode == 2'b00 || mode == 2'b11) begin
            for (int i = 0; i < len; i++) ob[i] = pb[i];
            olen = len;
            exp_byp++;
        end else if (mode == 2'b10 && pre_tagged) begin
            for (int i = 0; i < len; i++) ob[i] = pb[i];
            ob[14] = exp_tci[15:8];
            ob[15] = exp_tci[7:0];
            olen = len;
            exp_rep++;
        end else begin
            for (int i = 0; i < O; i++) ob[i] = pb[i];
            ob[12] = 8'h81; ob[13] = 8'h00; ob[14] = exp_tci[15:8]; ob[15] = exp_tci[7:0];
            for (int i = O; i < len; i++) ob[i+4] = pb[i];
            olen = len + 4;
            exp_ins++;
        end
        nbo = (olen + NB - 1) / NB;
        for (int b = 0; b < nbo; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < NB; j++) begin
                if (b * NB + j < olen) begin
                    d[8*j +: 8] = ob[b*NB+j];
                    k[j] = 1'b1;
                end
            end
            exp_data_q.push_back(d);
            exp_keep_q.push_back(k);
            exp_last_q.push_back(b == nbo - 1);
        end
        nbi = (len + NB - 1) / NB;
        for (int b = 0; b < nbi; b++) begin
            d = '0;
            k = '0;
            for (int j = 0; j < NB; j++) begin
                if (b * NB + j < len) begin
                    d[8*j +: 8] = pb[b*NB+j];
                    k[j] = 1'b1;
                end
            end
            if (b == 0) begin
                route_in = route; pcp_in = pcp; mode_in = mode;
            end else begin
                route_in = ~route; pcp_in = ~pcp; mode_in = mode ^ 2'b11;
            end
            drive_beat(d, k, b == nbi - 1);
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (exp_data_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge aclk);
        end
        if (!done) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_data_q.size());
        end
        repeat (2) @(posedge aclk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [DW-1:0] d;
        aresetn = 1'b0;
        route_in = '0; pcp_in = '0; mode_in = '0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("rst_tdata",  m_axis_tdata, '0);
        chk("rst_tkeep",  DW'(m_axis_tkeep), '0);
        chk("rst_tlast",  DW'(m_axis_tlast), DW'(1'b0));
        chk("rst_tready", DW'(s_axis_tready), DW'(1'b0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        mon_en = 1'b1;

        // route 0x0243: route[9:6]=1001, route[1:0]=11 -> VID 0x903, TCI 0x0903
        send_pkt(60, 2'b01, 14'h0243, 3'd0, 16'h0903, 1'b0);
        wait_idle();

        // full beat: drain beat follows and input stalls exactly one cycle
        send_pkt(64, 2'b01, 14'h0243, 3'd0, 16'h0903, 1'b0);
        @(negedge aclk);
        chk("drain_tready_low", DW'(s_axis_tready), DW'(1'b0));
        @(negedge aclk);
        chk("drain_tready_high", DW'(s_axis_tready), DW'(1'b1));
        wait_idle();

        // route 0x0041, pcp 3 -> VID 0x101, TCI 0x6101; output ready toggling
        rdy_mode = 1'b1;
        send_pkt(150, 2'b01, 14'h0041, 3'd3, 16'h6101, 1'b0);
        wait_idle();
        rdy_mode = 1'b0;

        // already tagged, pcp 5 route 0 -> TCI 0xA000
        send_pkt(70, 2'b10, 14'h0000, 3'd5, 16'hA000, 1'b1);
        wait_idle();
        // replace mode on an untagged frame inserts; route 0x3FFF pcp 7 -> TCI 0xEF03
        send_pkt(20, 2'b10, 14'h3FFF, 3'd7, 16'hEF03, 1'b0);
        wait_idle();
        send_pkt(40, 2'b11, 14'h1234, 3'd2, 16'h0000, 1'b0);
        wait_idle();

        // reset in the middle of a 3-beat frame
        mon_en = 1'b0;
        route_in = 14'h0243; pcp_in = 3'd0; mode_in = 2'b01;
        d = '1;
        drive_beat(d, '1, 1'b0);
        drive_beat(d, '1, 1'b0);
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_rst_tvalid", DW'(m_axis_tvalid), DW'(1'b0));
        chk("async_rst_tready", DW'(s_axis_tready), DW'(1'b0));
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        exp_ins = 0; exp_rep = 0; exp_byp = 0;
        @(posedge aclk);
        #1;
        mon_en = 1'b1;
        send_pkt(60, 2'b01, 14'h0243, 3'd0, 16'h0903, 1'b0);
        wait_idle();

        send_pkt(100, 2'b00, 14'h0243, 3'd1, 16'h0000, 1'b0);
        wait_idle();
        send_pkt(10, 2'b01, 14'h0243, 3'd1, 16'h0000, 1'b0);
        wait_idle();
`ifdef VIU_TAG_STATS_EN
        chk("stat_bypassed", DW'(stat_bypassed), DW'(32'd2));
        chk("stat_inserted", DW'(stat_inserted), DW'(exp_ins));
        chk("stat_replaced", DW'(stat_replaced), DW'(exp_rep));
`endif
        chk("queue_empty", DW'(exp_data_q.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish within 500000 time units");
        err_cnt++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $fatal(1, "watchdog expired");
    end

endmodule
